icache: RTL and testbench
=========================

# icache

Direct-mapped, read-only instruction cache between the instruction-fetch unit and the memory controller (MC). It holds BLOCK_SIZE-byte lines, answers hits one cycle after request, and on a miss requests the whole aligned block from the MC. It is the initiator side of the MC instruction-fetch handshake (ICMC_en/ICMC_addr out, MCIC_en/MCIC_block in).

## Interface
- BLOCK_SIZE, 16: bytes per line; power of two, ≥4
- LINE_NUM, 16: number of lines; power of two
- Sys_clk  in  1  clock, all state on rising edge
- Sys_rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- Sys_rdy  in  1  global enable; low = hold all state and outputs
- IFIC_en  in  1  one-cycle fetch request pulse
- IFIC_addr  in  32  fetch byte address; bits [1:0] ignored
- ICIF_en  out  1  one-cycle response pulse
- ICIF_inst  out  32  instruction word, valid while ICIF_en=1
- ICMC_en  out  1  block request to MC; held high until MCIC_en
- ICMC_addr  out  32  block-aligned address of requested line
- MCIC_en  in  1  one-cycle pulse: MCIC_block valid
- MCIC_block  in  8*BLOCK_SIZE  line data; byte at base+k in bits [8k+7:8k]
- clear  in  1  flush pending fetch (branch mispredict/rollback)

## Operation
- Address split: offset = addr[log2(BLOCK_SIZE)-1:0], index = next log2(LINE_NUM) bits, tag = remaining upper bits.
- Storage: per line valid bit, tag, data. Reset clears all valid bits; data/tag arrays not reset.
- Instruction word = bytes offset[..:2]*4 .. +3 of line, little-endian.
- States: IDLE, MISS.
- IDLE, IFIC_en=1, clear=0: hit (valid && tag match) → ICIF_en=1, ICIF_inst=word next cycle, stay IDLE. Miss → latch address, ICMC_en=1, ICMC_addr={tag,index,0s} next cycle, go MISS.
- MISS: ICMC_en, ICMC_addr held stable. On MCIC_en=1: write line (data, tag, valid=1); next cycle ICIF_en=1 with requested word, ICMC_en=0, go IDLE.
- clear=1 (any state) has priority: ICIF_en=0 next cycle, ICMC_en=0 next cycle, state IDLE, pending request dropped. If MCIC_en=1 same cycle as clear, line is still written, no response.
- MCIC_en in IDLE (stale after clear) ignored; no array write.
- IFIC_en in MISS ignored; IF issues no new request until ICIF_en seen.
- Sys_rdy=0: no state/array/output change; MCIC_en, IFIC_en in that cycle are ignored (MC also stalls under Sys_rdy).

## Timing
- Reset values: ICIF_en=0, ICIF_inst=0, ICMC_en=0, ICMC_addr=0, state IDLE, all valid=0. Async assertion mid-miss drops ICMC_en immediately.
- Hit latency: request edge T → ICIF_en at T+1. Back-to-back hits sustain one per cycle.
- Miss: request at T → ICMC_en high from T+1; MCIC_en at M → ICIF_en at M+1, ICMC_en low at M+1.
- ICIF_en is always exactly one cycle wide; deasserted in every cycle not listed above.
- Array write and response word come from MCIC_block directly (no re-read); refill of line X followed by hit request to X at M+1 sees new data.

## Test plan
- Cold miss: reset, IFIC_addr=0x0000_0104 → ICMC_en=1, ICMC_addr=0x0000_0100 next cycle; MC returns byte k = 0x10+k → ICIF_en one cycle after MCIC_en, ICIF_inst=0x17161514, ICMC_en=0.
- Hit: then request 0x0000_0108, 0x0000_010C in consecutive cycles → ICIF_inst=0x1B1A1918 then 0x1F1E1D1C on following cycles, ICMC_en stays 0.
- Conflict: request 0x0000_0204 (index 0, tag 2) → miss, ICMC_addr=0x0000_0200; afterwards 0x0000_0104 misses again.
- Clear mid-miss: miss at 0x0000_0300, assert clear two cycles later → ICMC_en=0 next cycle, no ICIF_en; stray MCIC_en later ignored; 0x0000_0300 then misses.
- Async reset mid-miss: Sys_rst_n low while ICMC_en=1 → all outputs 0 without clock edge; after release 0x0000_0108 misses.
- Stall: Sys_rdy=0 for 3 cycles during MISS with MCIC_en pulse → no response; ICMC_en held; response follows MCIC_en once Sys_rdy=1.

Source files
------------

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache between the fetch unit and the memory controller.
// Hits answer one cycle after the request; misses fetch the whole aligned line from the MC.
module icache #(
    parameter int BLOCK_SIZE = 16,
    parameter int LINE_NUM   = 16
) (
    input  logic                    Sys_clk,
    input  logic                    Sys_rst_n,
    input  logic                    Sys_rdy,
    input  logic                    IFIC_en,
    input  logic [31:0]             IFIC_addr,
    output logic                    ICIF_en,
    output logic [31:0]             ICIF_inst,
    output logic                    ICMC_en,
    output logic [31:0]             ICMC_addr,
    input  logic                    MCIC_en,
    input  logic [8*BLOCK_SIZE-1:0] MCIC_block,
    input  logic                    clear,
    output logic                    dbg_state
);

    // Handshake: IFIC_en and MCIC_en are single-cycle valid pulses with no ready
    // back-pressure; ICMC_en is a level held until the MC answers with MCIC_en.
    // Sys_rdy=0 freezes everything and discards any pulse in that cycle.

    localparam int OFF_W = $clog2(BLOCK_SIZE);
    localparam int IDX_W = $clog2(LINE_NUM);
    localparam int TAG_W = 32 - OFF_W - IDX_W;

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [LINE_NUM-1:0]     valid_q;
    logic [TAG_W-1:0]        tag_mem  [LINE_NUM];
    logic [8*BLOCK_SIZE-1:0] data_mem [LINE_NUM];

    logic [31:0] req_addr_q, req_addr_d;
    logic        icif_en_d, icmc_en_d, line_we;
    logic [31:0] icif_inst_d, icmc_addr_d;

    logic [IDX_W-1:0] req_idx, fill_idx;
    logic [TAG_W-1:0] req_tag, fill_tag;
    logic             hit;
    logic             unused_bits;

    assign req_idx  = IFIC_addr[OFF_W+IDX_W-1:OFF_W];
    assign req_tag  = IFIC_addr[31:OFF_W+IDX_W];
    assign fill_idx = req_addr_q[OFF_W+IDX_W-1:OFF_W];
    assign fill_tag = req_addr_q[31:OFF_W+IDX_W];
    assign hit      = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

    assign dbg_state   = state_q;
    assign unused_bits = ^{IFIC_addr[1:0], req_addr_q[1:0]};

    // Little-endian word at the byte offset; the low two offset bits are dropped.
    function automatic logic [31:0] pick_word(input logic [8*BLOCK_SIZE-1:0] line,
                                              input logic [OFF_W-1:0]        off);
        logic [OFF_W-1:0] w;
        w = off >> 2;
        return line[{w, 5'b00000} +: 32];
    endfunction

    always_comb begin
        state_d     = state_q;
        req_addr_d  = req_addr_q;
        icif_en_d   = ICIF_en;
        icif_inst_d = ICIF_inst;
        icmc_en_d   = ICMC_en;
        icmc_addr_d = ICMC_addr;
        line_we     = 1'b0;
        if (Sys_rdy) begin
            icif_en_d = 1'b0;
            // A refill arriving alongside clear still lands in the array.
            line_we   = (state_q == MISS) && MCIC_en;
            if (clear) begin
                state_d   = IDLE;
                icmc_en_d = 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (IFIC_en) begin
                            if (hit) begin
                                icif_en_d   = 1'b1;
                                icif_inst_d = pick_word(data_mem[req_idx], IFIC_addr[OFF_W-1:0]);
                            end else begin
                                req_addr_d  = IFIC_addr;
                                icmc_en_d   = 1'b1;
                                icmc_addr_d = {IFIC_addr[31:OFF_W], {OFF_W{1'b0}}};
                                state_d     = MISS;
                            end
                        end
                    end
                    MISS: begin
                        if (MCIC_en) begin
                            icif_en_d   = 1'b1;
                            icif_inst_d = pick_word(MCIC_block, req_addr_q[OFF_W-1:0]);
                            icmc_en_d   = 1'b0;
                            state_d     = IDLE;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
        if (!Sys_rst_n) begin
            state_q    <= IDLE;
            req_addr_q <= '0;
            ICIF_en    <= 1'b0;
            ICIF_inst  <= '0;
            ICMC_en    <= 1'b0;
            ICMC_addr  <= '0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            ICIF_en    <= icif_en_d;
            ICIF_inst  <= icif_inst_d;
            ICMC_en    <= icmc_en_d;
            ICMC_addr  <= icmc_addr_d;
            if (line_we) valid_q[fill_idx] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; valid_q alone qualifies them.
    always_ff @(posedge Sys_clk) begin
        if (line_we) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= MCIC_block;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cold miss, hits, conflict, clear, async reset and stall.
module tb_icache;

    logic         Sys_clk = 1'b0;
    logic         Sys_rst_n;
    logic         Sys_rdy;
    logic         IFIC_en;
    logic [31:0]  IFIC_addr;
    logic         ICIF_en;
    logic [31:0]  ICIF_inst;
    logic         ICMC_en;
    logic [31:0]  ICMC_addr;
    logic         MCIC_en;
    logic [127:0] MCIC_block;
    logic         clear;
    logic         dbg_state;

    int passed = 0;
    int total  = 0;

    icache #(.BLOCK_SIZE(16), .LINE_NUM(16)) dut (
        .Sys_clk   (Sys_clk),
        .Sys_rst_n (Sys_rst_n),
        .Sys_rdy   (Sys_rdy),
        .IFIC_en   (IFIC_en),
        .IFIC_addr (IFIC_addr),
        .ICIF_en   (ICIF_en),
        .ICIF_inst (ICIF_inst),
        .ICMC_en   (ICMC_en),
        .ICMC_addr (ICMC_addr),
        .MCIC_en   (MCIC_en),
        .MCIC_block(MCIC_block),
        .clear     (clear),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 Sys_clk = ~Sys_clk;

    task automatic tick();
        @(posedge Sys_clk);
        #1;
    endtask

    function automatic logic [127:0] mk_block(input logic [7:0] b);
        logic [127:0] blk;
        for (int k = 0; k < 16; k++) blk[8*k +: 8] = b + 8'(k);
        return blk;
    endfunction

    // driver tasks
    task automatic fetch(input logic [31:0] addr);
        IFIC_en   = 1'b1;
        IFIC_addr = addr;
        tick();
        IFIC_en   = 1'b0;
    endtask

    task automatic mc_return(input logic [7:0] b);
        MCIC_en    = 1'b1;
        MCIC_block = mk_block(b);
        tick();
        MCIC_en    = 1'b0;
    endtask

    task automatic test_reset();
        Sys_rst_n = 1'b0;
        tick();
        tick();
        total++; if (ICIF_en !== 1'b0) $display("FAIL reset_icif_en: got %0b want 0", ICIF_en); else passed++;
        total++; if (ICIF_inst !== 32'h0) $display("FAIL reset_icif_inst: got %h want 0", ICIF_inst); else passed++;
        total++; if (ICMC_en !== 1'b0) $display("FAIL reset_icmc_en: got %0b want 0", ICMC_en); else passed++;
        total++; if (ICMC_addr !== 32'h0) $display("FAIL reset_icmc_addr: got %h want 0", ICMC_addr); else passed++;
        total++; if (dbg_state !== 1'b0) $display("FAIL reset_state: got %0b want 0", dbg_state); else passed++;
        Sys_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_cold_miss();
        fetch(32'h0000_0104);
        total++; if (ICMC_en !== 1'b1) $display("FAIL cold_icmc_en: got %0b want 1", ICMC_en); else passed++;
        total++; if (ICMC_addr !== 32'h0000_0100) $display("FAIL cold_icmc_addr: got %h want 00000100", ICMC_addr); else passed++;
        total++; if (ICIF_en !== 1'b0) $display("FAIL cold_no_resp: got %0b want 0", ICIF_en); else passed++;
        tick();
        total++; if (ICMC_en !== 1'b1) $display("FAIL cold_icmc_held: got %0b want 1", ICMC_en); else passed++;
        mc_return(8'h10);
        total++; if (ICIF_en !== 1'b1) $display("FAIL cold_resp_en: got %0b want 1", ICIF_en); else passed++;
        total++; if (ICIF_inst !== 32'h1716_1514) $display("FAIL cold_resp_inst: got %h want 17161514", ICIF_inst); else passed++;
        total++; if (ICMC_en !== 1'b0) $display("FAIL cold_icmc_drop: got %0b want 0", ICMC_en); else passed++;
        tick();
        total++; if (ICIF_en !== 1'b0) $display("FAIL cold_resp_width: got %0b want 0", ICIF_en); else passed++;
    endtask

    task automatic test_back_to_back();
        fetch(32'h0000_0108);
        total++; if (ICIF_en !== 1'b1) $display("FAIL hit0_en: got %0b want 1", ICIF_en); else passed++;
        total++; if (ICIF_inst !== 32'h1B1A_1918) $display("FAIL hit0_inst: got %h want 1b1a1918", ICIF_inst); else passed++;
        fetch(32'h0000_010C);
        total++; if (ICIF_en !== 1'b1) $display("FAIL hit1_en: got %0b want 1", ICIF_en); else passed++;
        total++; if (ICIF_inst !== 32'h1F1E_1D1C) $display("FAIL hit1_inst: got %h want 1f1e1d1c", ICIF_inst); else passed++;
        total++; if (ICMC_en !== 1'b0) $display("FAIL hit_icmc_en: got %0b want 0", ICMC_en); else passed++;
        tick();
        total++; if (ICIF_en !== 1'b0) $display("FAIL hit_resp_width: got %0b want 0", ICIF_en); else passed++;
    endtask

    task automatic test_conflict();
        fetch(32'h0000_0204);
        total++; if (ICMC_en !== 1'b1) $display("FAIL conf_icmc_en: got %0b want 1", ICMC_en); else passed++;
        total++; if (ICMC_addr !== 32'h0000_0200) $display("FAIL conf_icmc_addr: got %h want 00000200", ICMC_addr); else passed++;
        mc_return(8'h40);
        total++; if (ICIF_inst !== 32'h4746_4544) $display("FAIL conf_inst: got %h want 47464544", ICIF_inst); else passed++;
        tick();
        fetch(32'h0000_0104);
        total++; if (ICMC_en !== 1'b1) $display("FAIL conf_remiss_en: got %0b want 1", ICMC_en); else passed++;
        total++; if (ICMC_addr !== 32'h0000_0100) $display("FAIL conf_remiss_addr: got %h want 00000100", ICMC_addr); else passed++;
        mc_return(8'h10);
        total++; if (ICIF_inst !== 32'h1716_1514) $display("FAIL conf_refill_inst: got %h want 17161514", ICIF_inst); else passed++;
        tick();
    endtask

    task automatic test_clear();
        fetch(32'h0000_0300);
        total++; if (ICMC_en !== 1'b1) $display("FAIL clr_icmc_en: got %0b want 1", ICMC_en); else passed++;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        total++; if (ICMC_en !== 1'b0) $display("FAIL clr_icmc_drop: got %0b want 0", ICMC_en); else passed++;
        total++; if (ICIF_en !== 1'b0) $display("FAIL clr_no_resp: got %0b want 0", ICIF_en); else passed++;
        total++; if (dbg_state !== 1'b0) $display("FAIL clr_state: got %0b want 0", dbg_state); else passed++;
        tick();
        mc_return(8'h80);
        total++; if (ICIF_en !== 1'b0) $display("FAIL clr_stray_mc: got %0b want 0", ICIF_en); else passed++;
        tick();
        fetch(32'h0000_0300);
        total++; if (ICMC_en !== 1'b1) $display("FAIL clr_remiss_en: got %0b want 1", ICMC_en); else passed++;
        total++; if (ICMC_addr !== 32'h0000_0300) $display("FAIL clr_remiss_addr: got %h want 00000300", ICMC_addr); else passed++;
        mc_return(8'h80);
        total++; if (ICIF_inst !== 32'h8382_8180) $display("FAIL clr_refill_inst: got %h want 83828180", ICIF_inst); else passed++;
        tick();
    endtask

    task automatic test_async_reset();
        fetch(32'h0000_0500);
        total++; if (ICMC_en !== 1'b1) $display("FAIL ar_icmc_en: got %0b want 1", ICMC_en); else passed++;
        #1;
        Sys_rst_n = 1'b0;
        #1;
        total++; if (ICMC_en !== 1'b0) $display("FAIL ar_icmc_en_drop: got %0b want 0", ICMC_en); else passed++;
        total++; if (ICMC_addr !== 32'h0) $display("FAIL ar_icmc_addr: got %h want 0", ICMC_addr); else passed++;
        total++; if (ICIF_en !== 1'b0 || ICIF_inst !== 32'h0) $display("FAIL ar_icif: got %0b/%h want 0/0", ICIF_en, ICIF_inst); else passed++;
        tick();
        Sys_rst_n = 1'b1;
        tick();
        fetch(32'h0000_0108);
        total++; if (ICMC_en !== 1'b1) $display("FAIL ar_remiss_en: got %0b want 1", ICMC_en); else passed++;
        total++; if (ICMC_addr !== 32'h0000_0100) $display("FAIL ar_remiss_addr: got %h want 00000100", ICMC_addr); else passed++;
        mc_return(8'h10);
        total++; if (ICIF_inst !== 32'h1B1A_1918) $display("FAIL ar_refill_inst: got %h want 1b1a1918", ICIF_inst); else passed++;
        tick();
    endtask

    task automatic test_stall();
        fetch(32'h0000_0600);
        total++; if (ICMC_addr !== 32'h0000_0600) $display("FAIL stall_icmc_addr: got %h want 00000600", ICMC_addr); else passed++;
        Sys_rdy    = 1'b0;
        MCIC_en    = 1'b1;
        MCIC_block = mk_block(8'hA0);
        tick();
        MCIC_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (ICIF_en !== 1'b0) $display("FAIL stall_no_resp[%0d]: got %0b want 0", i, ICIF_en); else passed++;
            total++; if (ICMC_en !== 1'b1) $display("FAIL stall_icmc_held[%0d]: got %0b want 1", i, ICMC_en); else passed++;
        end
        Sys_rdy = 1'b1;
        tick();
        total++; if (ICIF_en !== 1'b0) $display("FAIL stall_mc_ignored: got %0b want 0", ICIF_en); else passed++;
        total++; if (ICMC_en !== 1'b1) $display("FAIL stall_icmc_still: got %0b want 1", ICMC_en); else passed++;
        mc_return(8'hA0);
        total++; if (ICIF_en !== 1'b1) $display("FAIL stall_resp_en: got %0b want 1", ICIF_en); else passed++;
        total++; if (ICIF_inst !== 32'hA3A2_A1A0) $display("FAIL stall_resp_inst: got %h want a3a2a1a0", ICIF_inst); else passed++;
        total++; if (ICMC_en !== 1'b0) $display("FAIL stall_icmc_drop: got %0b want 0", ICMC_en); else passed++;
        tick();
    endtask

    initial begin
        Sys_rst_n  = 1'b0;
        Sys_rdy    = 1'b1;
        IFIC_en    = 1'b0;
        IFIC_addr  = 32'h0;
        MCIC_en    = 1'b0;
        MCIC_block = '0;
        clear      = 1'b0;
        test_reset();
        test_cold_miss();
        test_back_to_back();
        test_conflict();
        test_clear();
        test_async_reset();
        test_stall();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
